// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit '+'/'*' expressions terminated by '=' ('*' binds tighter).
// Optional macro OVERFLOW_DET_EN adds a sticky per-expression overflow flag reported on ovf.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [7:0]       in,
  input  logic             in_vld,
  output logic [WIDTH-1:0] result,
  output logic             res_vld,
  output logic             err,
  output logic             ovf
);

  typedef enum logic [1:0] {S_START, S_NUM, S_OPT, S_ERR} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d, prod_q, prod_d, result_q, result_d;
  logic             res_vld_q, res_vld_d, err_q, err_d;
  logic [WIDTH-1:0] mul_res, add_res;
  logic             is_digit, is_plus, is_mul, is_eq;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_plus  = (in == 8'h2B);
  assign is_mul   = (in == 8'h2A);
  assign is_eq    = (in == 8'h3D);

`ifdef OVERFLOW_DET_EN
  logic [WIDTH+3:0] mul_full;
  logic [WIDTH:0]   add_full;
  logic             mul_ovf, add_ovf;
  logic             flag_q, flag_d, ovf_q, ovf_d;

  // Digits never exceed 9, so four extra product bits capture everything lost.
  assign mul_full = {4'b0000, prod_q} * {{WIDTH{1'b0}}, in[3:0]};
  assign add_full = {1'b0, sum_q} + {1'b0, prod_q};
  assign mul_res  = mul_full[WIDTH-1:0];
  assign add_res  = add_full[WIDTH-1:0];
  assign mul_ovf  = |mul_full[WIDTH+3:WIDTH];
  assign add_ovf  = add_full[WIDTH];
  assign ovf      = ovf_q;
`else
  logic [WIDTH-1:0] digit;

  assign digit   = {{(WIDTH-4){1'b0}}, in[3:0]};
  assign mul_res = prod_q * digit;
  assign add_res = sum_q + prod_q;
  assign ovf     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    prod_d    = prod_q;
    result_d  = result_q;
    res_vld_d = 1'b0;
    err_d     = err_q;
`ifdef OVERFLOW_DET_EN
    flag_d    = flag_q;
    ovf_d     = ovf_q;
`endif
    if (in_vld) begin
      case (state_q)
        S_START, S_OPT: begin
          if (is_digit) begin
            prod_d  = mul_res;
            state_d = S_NUM;
`ifdef OVERFLOW_DET_EN
            flag_d  = flag_q | mul_ovf;
`endif
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_NUM: begin
          if (is_mul) begin
            state_d = S_OPT;
          end else if (is_plus) begin
            sum_d   = add_res;
            prod_d  = {{(WIDTH-1){1'b0}}, 1'b1};
            state_d = S_OPT;
`ifdef OVERFLOW_DET_EN
            flag_d  = flag_q | add_ovf;
`endif
          end else if (is_eq) begin
            result_d  = add_res;
            res_vld_d = 1'b1;
            sum_d     = '0;
            prod_d    = {{(WIDTH-1){1'b0}}, 1'b1};
            state_d   = S_START;
`ifdef OVERFLOW_DET_EN
            ovf_d     = flag_q | add_ovf;
            flag_d    = 1'b0;
`endif
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        default: begin
          // Only '=' leaves the error state; it discards the partial expression silently.
          if (is_eq) begin
            state_d = S_START;
            err_d   = 1'b0;
            sum_d   = '0;
            prod_d  = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef OVERFLOW_DET_EN
            flag_d  = 1'b0;
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_START;
      sum_q     <= '0;
      prod_q    <= {{(WIDTH-1){1'b0}}, 1'b1};
      result_q  <= '0;
      res_vld_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef OVERFLOW_DET_EN
      flag_q    <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      prod_q    <= prod_d;
      result_q  <= result_d;
      res_vld_q <= res_vld_d;
      err_q     <= err_d;
`ifdef OVERFLOW_DET_EN
      flag_q    <= flag_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign result  = result_q;
  assign res_vld = res_vld_q;
  assign err     = err_q;

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: string-level expression model checked every cycle, plus literal spot checks.
module tb_expr_eval;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic [7:0]       in_ch = 8'h00;
  logic             in_vld = 1'b0;
  logic [WIDTH-1:0] result;
  logic             res_vld, err, ovf;

  expr_eval #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clr_n(clr_n), .in(in_ch), .in_vld(in_vld),
    .result(result), .res_vld(res_vld), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: characters of the current expression, a syntax-broken flag, expected outputs.
  byte              expr[$];
  bit               bad = 1'b0;
  logic [WIDTH-1:0] exp_result = '0;
  logic             exp_res_vld = 1'b0, exp_err = 1'b0, exp_ovf = 1'b0;
  bit               chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total_cnt++;
    if (act !== want) $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    else pass_cnt++;
  endtask

  function automatic bit is_dig(input byte c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic bit prefix_ok();
    for (int i = 0; i < expr.size(); i++) begin
      if (i % 2 == 0) begin
        if (!is_dig(expr[i])) return 1'b0;
      end else if (!(expr[i] == "+" || expr[i] == "*")) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Sum of products with every intermediate wrapped to WIDTH bits; ov records any lost bits.
  task automatic eval_expr(output logic [WIDTH-1:0] r, output bit ov);
    longint sum = 0, prod = 1, lim = 64'd1 << WIDTH;
    ov = 1'b0;
    foreach (expr[i]) begin
      if (is_dig(expr[i])) begin
        prod = prod * longint'(expr[i] - "0");
        if (prod >= lim) ov = 1'b1;
        prod = prod % lim;
      end else if (expr[i] == "+") begin
        sum = sum + prod;
        if (sum >= lim) ov = 1'b1;
        sum = sum % lim;
        prod = 1;
      end
    end
    sum = sum + prod;
    if (sum >= lim) ov = 1'b1;
    r = WIDTH'(sum % lim);
  endtask

  task automatic model_step(input bit v, input byte c);
    logic [WIDTH-1:0] r;
    bit ov;
    exp_res_vld = 1'b0;
    if (v) begin
      if (c == "=") begin
        if (bad) begin
          bad = 1'b0;
          expr.delete();
        end else if (expr.size() % 2 == 1) begin
          eval_expr(r, ov);
          exp_result  = r;
          exp_res_vld = 1'b1;
`ifdef OVERFLOW_DET_EN
          exp_ovf     = ov;
`endif
          expr.delete();
        end else begin
          bad = 1'b1;
        end
      end else if (!bad) begin
        expr.push_back(c);
        if (!prefix_ok()) bad = 1'b1;
      end
      exp_err = bad;
    end
  endtask

  task automatic model_reset();
    expr.delete();
    bad = 1'b0;
    exp_result = '0; exp_res_vld = 1'b0; exp_err = 1'b0; exp_ovf = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("result", 32'(result), 32'(exp_result));
      chk("res_vld", 32'(res_vld), 32'(exp_res_vld));
      chk("err", 32'(err), 32'(exp_err));
      chk("ovf", 32'(ovf), 32'(exp_ovf));
    end
  end

  // Called just after a negedge; returns just after the following negedge.
  task automatic step(input bit v, input byte c);
    in_vld = v;
    in_ch  = c;
    @(posedge clk);
    model_step(v, c);
    @(negedge clk);
  endtask

  task automatic run(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_result", 32'(result), 32'd0);
    clr_n = 1'b1;
    step(1'b0, 8'h00);

    run("3+4*5=");
    chk("lit_3+4*5", 32'(result), 32'd23);
    chk("lit_pulse", 32'(res_vld), 32'd1);
    step(1'b1, "2");
    chk("pulse_once", 32'(res_vld), 32'd0);
    run("*3*4+1=");
    chk("lit_2*3*4+1", 32'(result), 32'd25);
    run("0=");
    chk("lit_zero", 32'(result), 32'd0);
    chk("lit_zero_pulse", 32'(res_vld), 32'd1);

    run("3++");
    chk("lit_err_set", 32'(err), 32'd1);
    run("4=");
    chk("lit_err_clr", 32'(err), 32'd0);
    chk("lit_no_pulse", 32'(res_vld), 32'd0);
    run("7=");
    chk("lit_7", 32'(result), 32'd7);

    run("9*9*9*9*9*9=");
    chk("lit_9pow6", 32'(result), 32'd7153);
`ifdef OVERFLOW_DET_EN
    chk("lit_ovf6", 32'(ovf), 32'd1);
`else
    chk("lit_ovf6", 32'(ovf), 32'd0);
`endif
    run("9*9*9*9*9=");
    chk("lit_9pow5", 32'(result), 32'd59049);
    chk("lit_ovf5", 32'(ovf), 32'd0);

    step(1'b1, "5");
    step(1'b0, "x");
    step(1'b1, "*");
    step(1'b0, "+");
    step(1'b1, "6");
    step(1'b0, "=");
    step(1'b1, "=");
    chk("lit_5*6", 32'(result), 32'd30);
    step(1'b0, "=");

    run("1=2=");
    chk("lit_b2b", 32'(result), 32'd2);
    run("=5=");
    chk("lit_eq_start_err", 32'(result), 32'd2);
    run("4 ");
    chk("lit_space_err", 32'(err), 32'd1);
    run("=");
    run("6*=");
    chk("lit_eq_opt_err", 32'(err), 32'd1);
    run("=");

    run("8+7");
    #2;
    clr_n = 1'b0;
    model_reset();
    #1;
    chk("async_result", 32'(result), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    chk("async_vld", 32'(res_vld), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    run("1=");
    chk("lit_after_rst", 32'(result), 32'd1);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
